// File: rtl/regfile_access_ctrl.sv
// Request sequencer in front of a single-port register file: queues read/write
// requests and serialises them onto the shared rf_* bus, returning read data.
module regfile_access_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic              rf_enable,
    inout  wire  [DATA_W-1:0] rf_data,
    output logic              busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_CAP, RSP} state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t              fifo_q [FIFO_DEPTH];
    req_t              fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [2:0]        lat_q, lat_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic              rf_we_q, rf_we_d;
    logic              rf_en_q, rf_en_d;
    logic              push, pop, head_is_zero;
    req_t              head;

    assign req_ready    = !rst && (count_q != CNT_W'(FIFO_DEPTH));
    assign push         = req_valid && req_ready;
    assign pop          = (state_q == IDLE) && (count_q != '0);
    assign head         = fifo_q[rd_ptr_q];
    assign head_is_zero = (ZERO_REG != 0) && (head.addr == '0);

    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        rf_addr_d   = rf_addr_q;
        rf_we_d     = rf_we_q;
        rf_en_d     = rf_en_q;

        if (push) begin
            fifo_d[wr_ptr_q] = req_t'{we: req_we, addr: req_addr, wdata: req_wdata};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Bus outputs are computed for the *next* state so they leave the flops
        // aligned with it and never see a combinational path from req_*.
        case (state_q)
            IDLE: begin
                if (pop) begin
                    cmd_addr_d  = head.addr;
                    cmd_wdata_d = head.wdata;
                    if (head_is_zero) begin
                        if (!head.we) begin
                            state_d     = RSP;
                            rsp_valid_d = 1'b1;
                            rsp_addr_d  = '0;
                            rsp_rdata_d = '0;
                        end
                    end else if (head.we) begin
                        state_d   = WR;
                        rf_we_d   = 1'b1;
                        rf_addr_d = head.addr;
                    end else begin
                        state_d   = RD_WAIT;
                        rf_en_d   = 1'b1;
                        rf_addr_d = head.addr;
                        lat_d     = '0;
                    end
                end
            end
            WR: begin
                state_d = IDLE;
                rf_we_d = 1'b0;
            end
            RD_WAIT: begin
                lat_d = lat_q + 3'd1;
                if (lat_q == 3'(READ_LAT - 1)) state_d = RD_CAP;
            end
            RD_CAP: begin
                rsp_rdata_d = rf_data;
                rsp_addr_d  = cmd_addr_q;
                rsp_valid_d = 1'b1;
                rf_en_d     = 1'b0;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
            rf_addr_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_en_q     <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            lat_q       <= lat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rf_addr_q   <= rf_addr_d;
            rf_we_q     <= rf_we_d;
            rf_en_q     <= rf_en_d;
        end
    end

    assign rf_data   = (state_q == WR) ? cmd_wdata_q : {DATA_W{1'bz}};
    assign rf_addr   = rf_addr_q;
    assign rf_we     = rf_we_q;
    assign rf_enable = rf_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a register-file model on the shared bus plus an
// in-order request model that predicts every bus write and every read response.
module tb_regfile_access_ctrl;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int RL = 2;
    localparam int ZR = 1;
    localparam int NREG = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] rf_addr;
    logic              rf_we;
    logic              rf_enable;
    wire  [DATA_W-1:0] rf_data;
    logic              busy;

    regfile_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
        .READ_LAT(RL), .ZERO_REG(ZR)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_enable(rf_enable),
        .rf_data(rf_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Register-file model: returns garbage until enable has been held RL cycles,
    // and holds the bus at zero when idle so any stray DUT drive shows up.
    logic [DATA_W-1:0] rfm [NREG];
    int en_cnt = 0;
    always @(posedge clk) begin
        if (rst) en_cnt <= 0;
        else     en_cnt <= rf_enable ? en_cnt + 1 : 0;
        if (!rst && rf_we) rfm[rf_addr] <= rf_data;
    end
    assign rf_data = rf_we ? {DATA_W{1'bz}} :
                     (rf_enable ? ((en_cnt >= RL) ? rfm[rf_addr] : ~rfm[rf_addr]) : '0);

    // Request-order reference: architectural register contents and expected traffic.
    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } ad_t;
    logic [DATA_W-1:0] mm [NREG];
    ad_t exp_wr[$];
    ad_t exp_rsp[$];
    int n_we = 0, n_en = 0, n_rsp = 0;
    logic rnd_bp = 1'b0;

    function automatic void model_accept(input logic we, input logic [ADDR_W-1:0] a,
                                         input logic [DATA_W-1:0] d);
        ad_t e;
        e.a = a;
        if (ZR != 0 && a == '0) begin
            e.d = '0;
            if (!we) exp_rsp.push_back(e);
        end else if (we) begin
            mm[a] = d;
            e.d = d;
            exp_wr.push_back(e);
        end else begin
            e.d = mm[a];
            exp_rsp.push_back(e);
        end
    endfunction

    task automatic bus_monitor;
        logic pv = 1'b0, pr = 1'b0;
        logic [ADDR_W-1:0] pa = '0;
        logic [DATA_W-1:0] pd = '0;
        ad_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                tests++;
                if (rf_we && rf_enable) begin
                    fails++; $display("FAIL bus_excl: we=%b en=%b, required not both high", rf_we, rf_enable);
                end
                if (!rf_we && !rf_enable) begin
                    tests++;
                    if (rf_data !== '0) begin
                        fails++; $display("FAIL bus_release: rf_data=%h, required undriven by dut", rf_data);
                    end
                end
                if (rf_enable) n_en++;
                if (rf_we) begin
                    n_we++; tests++;
                    if (exp_wr.size() == 0) begin
                        fails++; $display("FAIL unexpected_write: addr=%0d data=%h", rf_addr, rf_data);
                    end else begin
                        e = exp_wr.pop_front();
                        if (rf_addr !== e.a || rf_data !== e.d) begin
                            fails++;
                            $display("FAIL bus_write: addr=%0d data=%h, required addr=%0d data=%h", rf_addr, rf_data, e.a, e.d);
                        end
                    end
                end
                if (pv && !pr) begin
                    tests++;
                    if (rsp_valid !== 1'b1 || rsp_addr !== pa || rsp_rdata !== pd) begin
                        fails++;
                        $display("FAIL rsp_hold: v=%b addr=%0d data=%h, required v=1 addr=%0d data=%h", rsp_valid, rsp_addr, rsp_rdata, pa, pd);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    n_rsp++; tests++;
                    if (exp_rsp.size() == 0) begin
                        fails++; $display("FAIL unexpected_rsp: addr=%0d data=%h", rsp_addr, rsp_rdata);
                    end else begin
                        e = exp_rsp.pop_front();
                        if (rsp_addr !== e.a || rsp_rdata !== e.d) begin
                            fails++;
                            $display("FAIL rsp_data: addr=%0d data=%h, required addr=%0d data=%h", rsp_addr, rsp_rdata, e.a, e.d);
                        end
                    end
                end
                pv = rsp_valid; pr = rsp_ready; pa = rsp_addr; pd = rsp_rdata;
            end
        end
    endtask

    task automatic rdy_toggler;
        forever begin
            @(posedge clk); #1;
            if (rnd_bp) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Presents one request, waits (bounded) for ready, returns 1ns after the accepting edge.
    task automatic push(input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int waits);
        waits = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && waits < 300) begin @(posedge clk); #1; waits++; end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL push_timeout: req_ready=%b after %0d cycles, required 1", req_ready, waits);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(we, a, d);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        rsp_ready = 1'b1;
        while ((busy || rsp_valid || exp_rsp.size() != 0 || exp_wr.size() != 0) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (n >= 500) begin
            fails++;
            $display("FAIL %s_drain: busy=%b pending_rsp=%0d pending_wr=%0d, required idle", tag, busy, exp_rsp.size(), exp_wr.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (req_ready !== 1'b0 || rf_we !== 1'b0 || rf_enable !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: ready=%b we=%b en=%b rv=%b busy=%b, required all 0", req_ready, rf_we, rf_enable, rsp_valid, busy);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1 || rsp_addr !== '0 || rsp_rdata !== '0 || rf_addr !== '0 || rf_data !== '0) begin
            fails++;
            $display("FAIL reset_release: ready=%b raddr=%0d rdata=%h rf_addr=%0d bus=%h, required 1/0/0/0/undriven", req_ready, rsp_addr, rsp_rdata, rf_addr, rf_data);
        end
    endtask

    task automatic test_basic;
        int w, n;
        push(1'b1, 6'd1, 32'hA5A5A5A5, w);
        @(posedge clk); #1;
        tests++;
        if (rf_we !== 1'b1 || rf_addr !== 6'd1 || rf_data !== 32'hA5A5A5A5) begin
            fails++; $display("FAIL wr_latency: we=%b addr=%0d data=%h, required 1/1/a5a5a5a5", rf_we, rf_addr, rf_data);
        end
        @(posedge clk); #1;
        tests++;
        if (rf_we !== 1'b0) begin
            fails++; $display("FAIL wr_pulse: we=%b one cycle later, required 0", rf_we);
        end
        push(1'b0, 6'd1, '0, w);
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        tests++;
        if (n != 2 + RL) begin
            fails++; $display("FAIL rd_latency: %0d edges after accept, required %0d", n, 2 + RL);
        end
        tests++;
        if (rsp_addr !== 6'd1 || rsp_rdata !== 32'hA5A5A5A5) begin
            fails++; $display("FAIL rd_basic: addr=%0d data=%h, required 1/a5a5a5a5", rsp_addr, rsp_rdata);
        end
        wait_idle("basic");
    endtask

    task automatic test_back_to_back;
        int w, tot = 0, base = n_rsp;
        push(1'b1, 6'd2, 32'h5A5A5A5A, w); tot += w;
        push(1'b0, 6'd2, '0, w);           tot += w;
        push(1'b1, 6'd2, 32'h0000FFFF, w); tot += w;
        push(1'b0, 6'd2, '0, w);           tot += w;
        tests++;
        if (tot != 0) begin
            fails++; $display("FAIL b2b_ready: %0d stall cycles, required 0", tot);
        end
        wait_idle("b2b");
        tests++;
        if (n_rsp - base != 2) begin
            fails++; $display("FAIL b2b_count: %0d responses, required 2", n_rsp - base);
        end
    endtask

    task automatic test_fifo_full;
        int w, tot = 0, base = n_rsp;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, ADDR_W'(10 + i), '0, w);
            tot += w;
        end
        tests++;
        if (tot != 0 || req_ready !== 1'b0) begin
            fails++; $display("FAIL fifo_full: stalls=%0d ready=%b, required 0/0", tot, req_ready);
        end
        repeat (6) @(posedge clk);
        #1;
        tests++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL fifo_stall: rv=%b ready=%b busy=%b, required 1/0/1", rsp_valid, req_ready, busy);
        end
        wait_idle("fifo");
        tests++;
        if (n_rsp - base != 5) begin
            fails++; $display("FAIL fifo_count: %0d responses, required 5", n_rsp - base);
        end
    endtask

    task automatic test_zero_reg;
        int w, we0 = n_we, en0 = n_en, r0 = n_rsp;
        push(1'b1, 6'd0, 32'hDEADBEEF, w);
        push(1'b0, 6'd0, '0, w);
        wait_idle("zero");
        tests++;
        if (n_we != we0 || n_en != en0 || n_rsp != r0 + 1) begin
            fails++;
            $display("FAIL zero_reg: we_cyc=%0d en_cyc=%0d rsp=%0d, required 0/0/1", n_we - we0, n_en - en0, n_rsp - r0);
        end
    endtask

    task automatic test_random;
        int w, nrd = 0, base = n_rsp;
        logic we;
        logic [ADDR_W-1:0] a;
        rnd_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = ADDR_W'($urandom_range(0, 7));
            if (!we) nrd++;
            push(we, a, $urandom, w);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rnd_bp = 1'b0;
        wait_idle("random");
        tests++;
        if (n_rsp - base != nrd) begin
            fails++; $display("FAIL random_count: %0d responses, required %0d", n_rsp - base, nrd);
        end
    endtask

    task automatic test_reset_mid;
        int w, en0, r0;
        rsp_ready = 1'b1;
        push(1'b0, 6'd5, '0, w);
        push(1'b0, 6'd6, '0, w);
        push(1'b0, 6'd7, '0, w);
        tests++;
        if (rf_enable !== 1'b1) begin
            fails++; $display("FAIL reset_pre: rf_enable=%b, required 1 (read in progress)", rf_enable);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (rf_enable !== 1'b0 || rf_we !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || rf_data !== '0) begin
            fails++;
            $display("FAIL reset_mid: en=%b we=%b rv=%b busy=%b bus=%h, required 0/0/0/0/undriven", rf_enable, rf_we, rsp_valid, busy, rf_data);
        end
        exp_rsp.delete();
        exp_wr.delete();
        rst = 1'b0;
        en0 = n_en; r0 = n_rsp;
        repeat (12) @(posedge clk);
        #1;
        tests++;
        if (n_en != en0 || n_rsp != r0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_flush: en_cyc=%0d rsp=%0d busy=%b ready=%b, required 0/0/0/1", n_en - en0, n_rsp - r0, busy, req_ready);
        end
    endtask

    task automatic test_rf_contents;
        for (int i = 0; i < NREG; i++) begin
            tests++;
            if (rfm[i] !== mm[i]) begin
                fails++; $display("FAIL rf_contents[%0d]: %h, required %h", i, rfm[i], mm[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            rfm[i] = $urandom;
            mm[i]  = rfm[i];
        end
        fork
            bus_monitor();
            rdy_toggler();
        join_none
        test_reset();
        test_basic();
        test_back_to_back();
        test_fifo_full();
        test_zero_reg();
        test_random();
        test_reset_mid();
        test_rf_contents();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
